me_frame_loader: RTL
====================

// Module: me_frame_loader
// PURPOSE
//  Writer/sequencer for the motion-estimation engine's memory write port and go/done handshake.
//  - Packs an 8-bit pixel stream into 64-bit words and writes 128 reference words, then 32 current words.
//  - Pulses go, waits for done, captures m_i/m_j and returns them on a valid/ready result port.
//  - Sits between the host pixel source and the engine. Drives its write clock domain from clk.
// PARAMETERS
//  REF_WORDS  128    64-bit words written to ref memory (32x32 search window = 1024 px)
//  CUR_WORDS  32     64-bit words written to cur memory (16x16 block = 256 px)
//  TIMEOUT    65535  max cycles in WAIT before error result (16-bit counter)
// PORTS
//  clk                input   1   single clock, also drives engine clk_write
//  reset              input   1   asynchronous, active-high
//  start              input   1   begin load; sampled only in IDLE
//  r_cfg              input   4   search range, latched at accepted start
//  s_data             input   8   pixel byte
//  s_valid            input   1   s_data valid
//  s_ready            output  1   loader accepts byte this cycle
//  address_write_ref  output  7   ref memory write address
//  data_write_ref     output  64  ref memory write data
//  write_enable_ref   output  1   ref write strobe
//  address_write_cur  output  5   cur memory write address
//  data_write_cur     output  64  cur memory write data
//  write_enable_cur   output  1   cur write strobe
//  r                  output  4   latched range to engine
//  go                 output  1   one-cycle engine start pulse
//  done               input   1   engine completion
//  m_i, m_j           input   8   engine motion vector
//  res_valid          output  1   result available
//  res_ready          input   1   consumer takes result
//  res_i, res_j       output  8   captured vector
//  res_err            output  1   1 = timeout, vector forced 0
//  busy               output  1   state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE. Every output 0, including r, addresses, data, strobes, go and res_*. Byte/word counters 0.
//  - FSM states: IDLE, LOAD_REF, LOAD_CUR, WR_LAST, GO, WAIT, RESULT.
//    - IDLE: start=1 -> latch r_cfg into r; go to LOAD_REF.
//    - LOAD_REF: s_ready=1. Byte accepted when s_valid&s_ready.
//      - First byte of a word goes to [63:56], eighth byte to [7:0].
//      - On the 8th accepted byte, the next cycle drives write_enable_ref=1 for exactly 1 cycle, with address = word count 0..127 and the packed word.
//      - After byte 1024 is accepted -> LOAD_CUR. No bubble: s_ready stays 1.
//    - LOAD_CUR: same packing into cur memory, address 0..31.
//      - After byte 256 is accepted -> WR_LAST (s_ready=0) while the final cur write strobes.
//    - WR_LAST -> GO. GO: go=1 for one cycle -> WAIT. So go rises 2 cycles after the last byte is accepted.
//    - WAIT: TIMEOUT counter cleared on entry.
//      - First cycle with done=1 -> capture m_i/m_j into res_i/res_j, res_err=0.
//      - If the counter reaches TIMEOUT first -> res_i=res_j=0, res_err=1.
//      - If done=1 coincides with the counter reaching TIMEOUT, done wins.
//      - Either outcome -> RESULT.
//    - RESULT: res_valid=1, res_* held stable until res_ready=1 -> res_valid=0, IDLE.
//  - s_ready=0 in every state except LOAD_REF/LOAD_CUR. Bytes offered elsewhere are not consumed.
//  - s_valid gaps stall packing with no data loss. A partial word is held indefinitely.
//  - start outside IDLE is ignored. r does not change until the next accepted start.
//  - Write strobes and go are never asserted in the same cycle.
//  - Address counters do not wrap: the final ref address is 127, the final cur address is 31.
//  - Reset mid-operation aborts immediately.
//    - Partial words are discarded. No write strobe or go is issued afterwards.
//    - The next start reloads from address 0.
//  - done=1 in any state other than WAIT is ignored.
// TESTING
//  - Reset mid-LOAD_REF after 100 bytes, then start -> first write_enable_ref at address 0 with fresh data. No stray strobe.
//  - start, r_cfg=4, stream bytes 0..1279 (mod 256) with s_valid=1:
//    - 128 ref strobes; word 0 = 0x0001020304050607, word 127 = 0xF8F9FAFBFCFDFEFF.
//    - 32 cur strobes; cur word 0 = 0x0001020304050607.
//    - go 2 cycles after the last byte; r=4.
//  - Random s_valid duty 30%, same data -> identical written words and addresses. s_ready=0 after byte 1280.
//  - done after 50 cycles with m_i=3, m_j=0xFE, res_ready held low 10 cycles -> res_valid=1, res_i=3, res_j=0xFE, res_err=0, stable until handshake, then busy=0.
//  - done never asserted, TIMEOUT=100 -> res_valid after 100 WAIT cycles with res_err=1 and res_i=res_j=0.
//  - start pulsed during WAIT, done pulsed during LOAD_CUR -> no effect; the sequence completes normally.

Source files
------------

// File: rtl/me_frame_loader.sv
// Loads ref/cur pixel memories of the motion-estimation engine from a byte stream, then runs the
// go/done handshake and returns the motion vector (or a timeout error) on a valid/ready port.
module me_frame_loader #(
  parameter int unsigned REF_WORDS = 128,
  parameter int unsigned CUR_WORDS = 32,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  r_cfg,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [6:0]  address_write_ref,
  output logic [63:0] data_write_ref,
  output logic        write_enable_ref,
  output logic [4:0]  address_write_cur,
  output logic [63:0] data_write_cur,
  output logic        write_enable_cur,
  output logic [3:0]  r,
  output logic        go,
  input  logic        done,
  input  logic [7:0]  m_i,
  input  logic [7:0]  m_j,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_i,
  output logic [7:0]  res_j,
  output logic        res_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle, StLoadRef, StLoadCur, StWrLast, StGo, StWait, StResult
  } state_e;

  localparam logic [6:0]  RefLast  = 7'(REF_WORDS - 1);
  localparam logic [6:0]  CurLast  = 7'(CUR_WORDS - 1);
  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

  state_e      state;
  logic [2:0]  byte_cnt;
  logic [6:0]  word_cnt;
  logic [55:0] pack;
  logic [15:0] wait_cnt;
  logic        accept;
  logic [63:0] word_full;

  assign s_ready   = (state == StLoadRef) || (state == StLoadCur);
  assign busy      = (state != StIdle);
  assign accept    = s_valid && s_ready;
  // Earliest byte ends up in [63:56] after eight shifts.
  assign word_full = {pack, s_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= StIdle;
      byte_cnt          <= 3'd0;
      word_cnt          <= 7'd0;
      pack              <= 56'd0;
      wait_cnt          <= 16'd0;
      address_write_ref <= 7'd0;
      data_write_ref    <= 64'd0;
      write_enable_ref  <= 1'b0;
      address_write_cur <= 5'd0;
      data_write_cur    <= 64'd0;
      write_enable_cur  <= 1'b0;
      r                 <= 4'd0;
      go                <= 1'b0;
      res_valid         <= 1'b0;
      res_i             <= 8'd0;
      res_j             <= 8'd0;
      res_err           <= 1'b0;
    end else begin
      write_enable_ref <= 1'b0;
      write_enable_cur <= 1'b0;
      go               <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            r        <= r_cfg;
            byte_cnt <= 3'd0;
            word_cnt <= 7'd0;
            state    <= StLoadRef;
          end
        end
        StLoadRef: begin
          if (accept) begin
            pack     <= word_full[55:0];
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd7) begin
              write_enable_ref  <= 1'b1;
              address_write_ref <= word_cnt;
              data_write_ref    <= word_full;
              if (word_cnt == RefLast) begin
                word_cnt <= 7'd0;
                state    <= StLoadCur;
              end else begin
                word_cnt <= word_cnt + 7'd1;
              end
            end
          end
        end
        StLoadCur: begin
          if (accept) begin
            pack     <= word_full[55:0];
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd7) begin
              write_enable_cur  <= 1'b1;
              address_write_cur <= word_cnt[4:0];
              data_write_cur    <= word_full;
              if (word_cnt == CurLast) begin
                word_cnt <= 7'd0;
                state    <= StWrLast;
              end else begin
                word_cnt <= word_cnt + 7'd1;
              end
            end
          end
        end
        StWrLast: begin
          go    <= 1'b1;
          state <= StGo;
        end
        StGo: begin
          wait_cnt <= 16'd0;
          state    <= StWait;
        end
        StWait: begin
          // done takes priority over a timeout in the same cycle.
          if (done) begin
            res_i     <= m_i;
            res_j     <= m_j;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= StResult;
          end else if (wait_cnt == WaitLast) begin
            res_i     <= 8'd0;
            res_j     <= 8'd0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= StResult;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        StResult: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
